// File: rtl/led_fade_pkg.sv
// Shared types and default constants for the LED PWM fader.
package led_fade_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    UP   = 2'd1,
    ON   = 2'd2,
    DOWN = 2'd3
  } fade_state_t;

  localparam int unsigned DEFAULT_PWM_BITS = 8;
  localparam int unsigned DEFAULT_STEP_DIV = 122070;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: fade state machine, brightness level and registered PWM drive.
// LED_PWM_FADER_GAMMA_EN selects a squared (gamma) duty curve instead of a linear one.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEFAULT_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                step_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out,
  output logic                fading
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
  localparam logic [PWM_BITS-1:0] LEVEL_ONE = PWM_BITS'(1);

  fade_state_t         state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty;
  logic                led_d;

`ifdef LED_PWM_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_ext;
  logic [2*PWM_BITS-1:0] level_sq;

  assign level_ext = {{PWM_BITS{1'b0}}, level_q};
  assign level_sq  = level_ext * level_ext;
  assign duty      = level_sq[2*PWM_BITS-1 -: PWM_BITS];
`else
  assign duty = level_q;
`endif

  // A request reversal wins over a coincident step tick, so the level never jumps.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      OFF: begin
        if (req) state_d = UP;
      end
      UP: begin
        if (!req) begin
          state_d = DOWN;
        end else if (level_q == LEVEL_MAX) begin
          state_d = ON;
        end else if (step_tick) begin
          level_d = level_q + 1'b1;
          if (level_q == LEVEL_MAX - LEVEL_ONE) state_d = ON;
        end
      end
      ON: begin
        if (!req) state_d = DOWN;
      end
      DOWN: begin
        if (req) begin
          state_d = UP;
        end else if (level_q == '0) begin
          state_d = OFF;
        end else if (step_tick) begin
          level_d = level_q - 1'b1;
          if (level_q == LEVEL_ONE) state_d = OFF;
        end
      end
    endcase
  end

  always_comb begin
    led_d = 1'b0;
    unique case (state_q)
      OFF:     led_d = 1'b0;
      ON:      led_d = 1'b1;
      UP,
      DOWN:    led_d = (duty > pwm_cnt);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      level_q <= '0;
      led_out <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      led_out <= led_d;
    end
  end

  assign fading = (state_q == UP) || (state_q == DOWN);

endmodule

// File: rtl/led_pwm_fader.sv
// Two-channel LED PWM fader: shared PWM counter and step timer, one fade channel per LED.
// Define LED_PWM_FADER_GAMMA_EN for a squared (perceptually linear) duty curve.
module led_pwm_fader
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEFAULT_PWM_BITS,
  parameter int unsigned STEP_DIV = DEFAULT_STEP_DIV
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] LED_IN,
  output logic [1:0] LED_OUT,
  output logic [1:0] FADING
);

  localparam int unsigned     STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                step_tick;

  assign step_tick = (step_cnt == STEP_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
      step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk      (CLK),
      .rst      (RST),
      .req      (LED_IN[i]),
      .step_tick(step_tick),
      .pwm_cnt  (pwm_cnt),
      .led_out  (LED_OUT[i]),
      .fading   (FADING[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader: PWM_BITS=4, one instance at STEP_DIV=4 and one at STEP_DIV=64.
module tb_led_pwm_fader;

`ifdef LED_PWM_FADER_GAMMA_EN
  localparam int unsigned RAMP_HI  = 18;
  localparam int unsigned DUTY8_HI = 4;
  localparam int unsigned REV_HI   = 3;
  localparam int unsigned CH1_HI   = 3;
`else
  localparam int unsigned RAMP_HI  = 27;
  localparam int unsigned DUTY8_HI = 8;
  localparam int unsigned REV_HI   = 9;
  localparam int unsigned CH1_HI   = 12;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] led_in_a = '0;
  logic [1:0] led_in_b = '0;
  logic [1:0] led_out_a, fading_a, led_out_b, fading_b;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  always #5 CLK = ~CLK;

  led_pwm_fader #(.PWM_BITS(4), .STEP_DIV(4)) dut_a (
    .CLK(CLK), .RST(RST), .LED_IN(led_in_a), .LED_OUT(led_out_a), .FADING(fading_a)
  );

  led_pwm_fader #(.PWM_BITS(4), .STEP_DIV(64)) dut_b (
    .CLK(CLK), .RST(RST), .LED_IN(led_in_b), .LED_OUT(led_out_b), .FADING(fading_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Two reset edges; returns at the negedge after the last one, so the next posedge is edge 1.
  task automatic reset_all();
    @(negedge CLK);
    RST = 1'b1;
    led_in_a = '0;
    led_in_b = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_state", {led_out_a, fading_a, led_out_b, fading_b}, 32'h0);
    RST = 1'b0;
  endtask

  // Channel 0 of dut_a ramps from level 0: UP from edge 1, ON at edge 60.
  task automatic ramp_ch0(input string tag);
    int unsigned hi;
    hi = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      hi += led_out_a[0];
      chk({tag, "_fading0"}, fading_a[0], (k < 60) ? 1 : 0);
      chk({tag, "_ch1_idle"}, {led_out_a[1], fading_a[1]}, 0);
    end
    chk({tag, "_high_count"}, hi, RAMP_HI);
    for (int k = 61; k <= 80; k++) begin
      @(negedge CLK);
      chk({tag, "_on"}, {led_out_a, fading_a}, 4'b0100);
    end
  endtask

  initial begin
    int unsigned hi0, hi1;
    int unsigned hi_p [4];

    // Reset and idle
    reset_all();
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      chk("idle", {led_out_a, fading_a, led_out_b, fading_b}, 32'h0);
    end

    // Ramp up on channel 0
    reset_all();
    led_in_a = 2'b01;
    ramp_ch0("ramp");

    // Duty at level 8 (edges 513..576 of dut_b)
    reset_all();
    led_in_b = 2'b01;
    for (int p = 0; p < 4; p++) hi_p[p] = 0;
    for (int k = 1; k <= 576; k++) begin
      @(negedge CLK);
      if (k >= 513) hi_p[(k - 513) / 16] += led_out_b[0];
    end
    for (int p = 0; p < 4; p++) chk("duty_level8", hi_p[p], DUTY8_HI);
    chk("duty_fading", fading_b, 2'b01);

    // Reversal on a tick edge (edge 32, level 7)
    reset_all();
    led_in_a = 2'b01;
    hi0 = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      chk("rev_fading0", fading_a[0], (k < 60) ? 1 : 0);
      if (k >= 33) hi0 += led_out_a[0];
      if (k == 31) led_in_a = 2'b00;
    end
    chk("rev_high_count", hi0, REV_HI);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      chk("rev_off", {led_out_a, fading_a}, 0);
    end

    // Reset mid-ramp at level 9 (edge 38), then ramp restarts from 0
    reset_all();
    led_in_a = 2'b01;
    for (int k = 1; k <= 37; k++) begin
      @(negedge CLK);
      chk("midrst_fading0", fading_a[0], 1);
    end
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_cleared", {led_out_a, fading_a}, 0);
    RST = 1'b0;
    ramp_ch0("restart");

    // Both channels, channel 1 dropped at edge 30 (level 7)
    reset_all();
    led_in_a = 2'b11;
    hi0 = 0;
    hi1 = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      hi0 += led_out_a[0];
      hi1 += led_out_a[1];
      chk("dual_fading0", fading_a[0], (k < 60) ? 1 : 0);
      chk("dual_fading1", fading_a[1], (k < 56) ? 1 : 0);
      if (k == 29) led_in_a = 2'b01;
    end
    chk("dual_ch0_high", hi0, RAMP_HI);
    chk("dual_ch1_high", hi1, CH1_HI);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      chk("dual_final", {led_out_a, fading_a}, 4'b0100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Downstream output stage for the LED counter block on the Cora Z7 board. It takes the 2-bit on/off LED request and drives the board LED pins with PWM. Each channel ramps brightness up or down linearly instead of switching hard. Each channel runs its own fade state machine; the PWM counter and step timer are shared.

## Interface
Parameters:
- PWM_BITS, 8: PWM counter width. Full-scale level M = 2^PWM_BITS - 1.
- STEP_DIV, 122070: CLK cycles per brightness step. Minimum 1.

Ports:
- CLK  input  1  system clock, 125 MHz.
- RST  input  1  reset, synchronous, active-high.
- LED_IN  input  [1:0]  per-channel on/off request, synchronous to CLK.
- LED_OUT  output  [1:0]  PWM drive to the LED pins, registered.
- FADING  output  [1:0]  high while the channel is in UP or DOWN.

## Operation
- pwm_cnt: PWM_BITS wide, free-running, increments every cycle, wraps M→0.
- step_cnt: counts 0..STEP_DIV-1, then wraps. step_tick is a 1-cycle pulse when step_cnt == STEP_DIV-1.
- Per channel: a level register (0..M) and a state register (OFF, UP, ON, DOWN).
- State transitions, evaluated every cycle:
  - OFF: if LED_IN=1, go to UP.
  - UP:
    - If LED_IN=0, go to DOWN immediately, keeping the current level (reversal, no jump).
    - Otherwise, on step_tick, level += 1. When level reaches M, go to ON.
  - ON: if LED_IN=0, go to DOWN.
  - DOWN:
    - If LED_IN=1, go to UP.
    - Otherwise, on step_tick, level -= 1. When level reaches 0, go to OFF.
- Level saturates at 0 and M and never wraps.
- Reversal takes priority over a coincident step_tick: the level is unchanged on that cycle.
- duty = level, PWM_BITS wide.
- LED_OUT[i] on the next edge:
  - OFF: 0.
  - ON: 1 (full-on, no PWM gap).
  - Otherwise: duty > pwm_cnt.
- FADING[i] = (state == UP) or (state == DOWN), decoded directly from the state register.
- Channels are fully independent. Simultaneous requests on both channels are legal.
- RST, from any state including mid-ramp, takes effect on the next edge:
  - pwm_cnt = 0 and step_cnt = 0.
  - All states = OFF and all levels = 0.
  - LED_OUT = 2'b00 and FADING = 2'b00.

## Timing
- Reset values: LED_OUT = 0, FADING = 0, all internal counters and levels = 0, all states = OFF.
- LED_IN sampled at edge k: state changes at edge k, so FADING changes in the cycle after edge k.
- LED_OUT reflects the new state or level at edge k+1.
- A full ramp takes M steps, between (M-1)·STEP_DIV+1 and M·STEP_DIV cycles depending on step_cnt phase. With defaults: about 31.1 M cycles, about 0.25 s at 125 MHz.
- pwm_cnt and step_cnt both restart at 0 after reset. When 2^PWM_BITS divides STEP_DIV, each level is held for whole PWM periods.
- PWM period = 2^PWM_BITS cycles. The high count per period equals duty.

## Configuration
- LED_PWM_FADER_GAMMA_EN defined:
  - duty = (level·level) >> PWM_BITS, computed with a 2·PWM_BITS intermediate product.
  - Gives perceptually linear fades.
  - The ON state is still forced to 1.
- LED_PWM_FADER_GAMMA_EN undefined: duty = level, and no multiplier is instantiated.

## Structure
- Shared package led_fade_pkg:
  - State enum: OFF = 2'd0, UP = 2'd1, ON = 2'd2, DOWN = 2'd3.
  - Default constants for PWM_BITS and STEP_DIV.
- Sub-module led_fade_channel, one instance per LED bit. It contains:
  - the state register;
  - the level register;
  - the duty computation;
  - the LED_OUT and FADING outputs.
- The top level holds the shared pwm_cnt, step_cnt and step_tick, plus a 2-wide generate loop.

## Test plan
All scenarios use PWM_BITS=4 (M=15) unless noted.
- Reset and idle: RST high for 2 cycles, then LED_IN=00 for 200 cycles → LED_OUT=00 and FADING=00 throughout.
- Ramp up (STEP_DIV=4): LED_IN[0]=1 →
  - FADING[0]=1 after 1 cycle.
  - Level reaches 15 within 57–60 cycles, then FADING[0]=0.
  - LED_OUT[0] is a constant 1 afterwards.
  - LED_OUT[1] stays 0.
- Duty accuracy (STEP_DIV=64):
  - During the 4 PWM periods at level 8, LED_OUT[0] is high for 8 of every 16 cycles.
  - With LED_PWM_FADER_GAMMA_EN, it is high for 4 of 16.
- Reversal (STEP_DIV=4): drop LED_IN[0] when level=7 →
  - Next cycle: state DOWN, level still 7.
  - Level decrements to 0, then OFF with LED_OUT[0]=0.
  - FADING[0] stays 1 until OFF.
- Reset mid-ramp: assert RST at level 9 →
  - Next edge: LED_OUT=00, FADING=00, level=0.
  - After release with LED_IN still 1, the ramp restarts from 0.
- Simultaneous channels: LED_IN goes 00→11, then 11→01 mid-ramp →
  - Ch0 continues to ON.
  - Ch1 reverses and reaches OFF.
  - Neither channel disturbs the other's level sequence.
